// File: rtl/cpu_boot_loader.sv
// rtl/cpu_boot_loader.sv - boot sequencer: clear memory, stream program image in, hold then release core reset
//
// Purpose:
//   Optionally zeroes program memory, writes a streamed image one word per
//   handshake, holds the core in reset for a fixed count, then releases it.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   boot_start              one-cycle pulse, starts/restarts a boot from IDLE or RUN
//   load_valid/ready/data/last  program image stream
//   mem_we/addr/wdata       memory write port (registered, 1-cycle latency)
//   cpu_reset               active-high core reset, low only in RUN
//   busy, done, error       status: CLEAR/LOAD/HOLD, RUN, sticky image overflow
module cpu_boot_loader #(
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_WIDTH        = 32,
  parameter int LOAD_BASE         = 0,
  parameter int CLEAR_ON_BOOT     = 1,
  parameter int RESET_HOLD_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  boot_start,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_t;

  // One extra bit so an address past the top of memory is representable
  typedef logic [ADDR_WIDTH:0] cnt_t;

  localparam int          HOLD_LEN  = (RESET_HOLD_CYCLES < 1) ? 1 : RESET_HOLD_CYCLES;
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_LEN - 1);
  localparam cnt_t        BASE_CNT  = cnt_t'(LOAD_BASE);
  localparam cnt_t        CNT_MAX   = '1;

  state_t      state;
  cnt_t        addr_cnt;
  logic [31:0] hold_cnt;

  logic accept;
  logic in_range;
  logic overflow_seen;
  cnt_t cnt_next;

  assign accept        = load_valid & load_ready;
  assign in_range      = ~addr_cnt[ADDR_WIDTH];
  // The current word may itself be the first out-of-range one
  assign overflow_seen = error | ~in_range;
  // Saturate so an oversized image can never wrap back onto address 0
  assign cnt_next      = (addr_cnt == CNT_MAX) ? addr_cnt : addr_cnt + cnt_t'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      addr_cnt   <= '0;
      hold_cnt   <= '0;
      load_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RUN: begin
          mem_we <= 1'b0;
          if (boot_start) begin
            error     <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            busy      <= 1'b1;
            if (CLEAR_ON_BOOT != 0) begin
              // First clear write is issued on the entry edge itself
              state     <= S_CLEAR;
              mem_we    <= 1'b1;
              mem_addr  <= '0;
              mem_wdata <= '0;
              addr_cnt  <= cnt_t'(1);
            end else begin
              state      <= S_LOAD;
              load_ready <= 1'b1;
              addr_cnt   <= BASE_CNT;
            end
          end
        end

        S_CLEAR: begin
          // addr_cnt holds the next address to clear; the top bit marks completion
          if (addr_cnt[ADDR_WIDTH]) begin
            state      <= S_LOAD;
            mem_we     <= 1'b0;
            load_ready <= 1'b1;
            addr_cnt   <= BASE_CNT;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= addr_cnt[ADDR_WIDTH-1:0];
            addr_cnt <= addr_cnt + cnt_t'(1);
          end
        end

        S_LOAD: begin
          mem_we <= 1'b0;
          if (accept) begin
            if (in_range) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr_cnt[ADDR_WIDTH-1:0];
              mem_wdata <= load_data;
            end else begin
              error <= 1'b1;
            end
            addr_cnt <= cnt_next;
            if (load_last) begin
              load_ready <= 1'b0;
              if (overflow_seen) begin
                // Truncated image: never release the core
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state    <= S_HOLD;
                hold_cnt <= HOLD_LAST;
              end
            end
          end
        end

        S_HOLD: begin
          mem_we <= 1'b0;
          if (hold_cnt == 32'd0) begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 32'd1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// tb/tb_cpu_boot_loader.sv - scoreboard bench for cpu_boot_loader
module tb_cpu_boot_loader;

  logic clk;
  logic reset_n;

  // Instance A: 16-word memory, clear on boot, 8-cycle hold
  logic        a_boot, a_valid, a_last, a_ready, a_we, a_cpu_rst, a_busy, a_done, a_err;
  logic [31:0] a_data, a_wdata;
  logic [3:0]  a_addr;

  // Instance B: 4-word memory, no clear, zero hold (treated as 1)
  logic        b_boot, b_valid, b_last, b_ready, b_we, b_cpu_rst, b_busy, b_done, b_err;
  logic [31:0] b_data, b_wdata;
  logic [1:0]  b_addr;

  int tests = 0;
  int fails = 0;

  int a_exp;
  int b_exp;

  logic [3:0]  qa_addr[$];
  logic [31:0] qa_data[$];
  logic [1:0]  qb_addr[$];
  logic [31:0] qb_data[$];

  logic [3:0]  ea;
  logic [1:0]  eb;
  logic [31:0] ed_a, ed_b;

  cpu_boot_loader #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .LOAD_BASE(0), .CLEAR_ON_BOOT(1), .RESET_HOLD_CYCLES(8)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .boot_start(a_boot),
    .load_valid(a_valid), .load_ready(a_ready), .load_data(a_data), .load_last(a_last),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .cpu_reset(a_cpu_rst), .busy(a_busy), .done(a_done), .error(a_err)
  );

  cpu_boot_loader #(
    .ADDR_WIDTH(2), .DATA_WIDTH(32), .LOAD_BASE(0), .CLEAR_ON_BOOT(0), .RESET_HOLD_CYCLES(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .boot_start(b_boot),
    .load_valid(b_valid), .load_ready(b_ready), .load_data(b_data), .load_last(b_last),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .cpu_reset(b_cpu_rst), .busy(b_busy), .done(b_done), .error(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboards: every observed write must match the oldest expected write
  always @(negedge clk) begin
    if (reset_n && a_we) begin
      tests++;
      if (qa_addr.size() == 0) begin
        fails++;
        $display("FAIL a_write_unexpected: addr=%0d data=%h, none expected", a_addr, a_wdata);
      end else begin
        ea   = qa_addr.pop_front();
        ed_a = qa_data.pop_front();
        if (a_addr !== ea || a_wdata !== ed_a) begin
          fails++;
          $display("FAIL a_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   a_addr, a_wdata, ea, ed_a);
        end
      end
    end
    if (reset_n && b_we) begin
      tests++;
      if (qb_addr.size() == 0) begin
        fails++;
        $display("FAIL b_write_unexpected: addr=%0d data=%h, none expected", b_addr, b_wdata);
      end else begin
        eb   = qb_addr.pop_front();
        ed_b = qb_data.pop_front();
        if (b_addr !== eb || b_wdata !== ed_b) begin
          fails++;
          $display("FAIL b_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   b_addr, b_wdata, eb, ed_b);
        end
      end
    end
  end

  // All drive tasks start and end at posedge + 1
  task automatic pulse_boot_a();
    a_boot = 1'b1;
    @(posedge clk); #1;
    a_boot = 1'b0;
  endtask

  task automatic pulse_boot_b();
    b_boot = 1'b1;
    @(posedge clk); #1;
    b_boot = 1'b0;
  endtask

  task automatic push_clear_a();
    for (int i = 0; i < 16; i++) begin
      qa_addr.push_back(4'(i));
      qa_data.push_back(32'd0);
    end
  endtask

  task automatic send_a(input logic [31:0] d, input logic last);
    logic hs;
    hs      = 1'b0;
    a_valid = 1'b1;
    a_data  = d;
    a_last  = last;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      hs = a_ready;
      @(posedge clk); #1;
      if (hs) break;
    end
    if (!hs) begin
      tests++;
      fails++;
      $display("FAIL a_handshake_timeout: load_ready=%b, required 1", a_ready);
    end else begin
      if (a_exp < 16) begin
        qa_addr.push_back(a_exp[3:0]);
        qa_data.push_back(d);
      end
      a_exp++;
    end
  endtask

  task automatic send_b(input logic [31:0] d, input logic last);
    logic hs;
    hs      = 1'b0;
    b_valid = 1'b1;
    b_data  = d;
    b_last  = last;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      hs = b_ready;
      @(posedge clk); #1;
      if (hs) break;
    end
    if (!hs) begin
      tests++;
      fails++;
      $display("FAIL b_handshake_timeout: load_ready=%b, required 1", b_ready);
    end else begin
      if (b_exp < 4) begin
        qb_addr.push_back(b_exp[1:0]);
        qb_data.push_back(d);
      end
      b_exp++;
    end
  endtask

  // Cycles from the last handshake edge until cpu_reset falls on instance A
  task automatic wait_release_a(input int expected);
    int cyc;
    cyc = 0;
    while (a_cpu_rst === 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (cyc != expected) begin
      fails++;
      $display("FAIL a_release_latency: got %0d cycles, expected %0d", cyc, expected);
    end
    tests++;
    if ({a_cpu_rst, a_done, a_busy, a_err} !== 4'b0100) begin
      fails++;
      $display("FAIL a_run_state: cpu_reset,done,busy,error=%b, expected 0100",
               {a_cpu_rst, a_done, a_busy, a_err});
    end
  endtask

  task automatic check_drained(input string name);
    @(posedge clk); #1;
    tests++;
    if (qa_addr.size() != 0 || qb_addr.size() != 0) begin
      fails++;
      $display("FAIL %s_drained: pending a=%0d b=%0d, expected 0 0",
               name, qa_addr.size(), qb_addr.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_boot = 0; a_valid = 0; a_last = 0; a_data = '0;
    b_boot = 0; b_valid = 0; b_last = 0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({a_cpu_rst, a_we, a_busy, a_done, a_err, a_ready} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_a: got %b, expected 100000",
               {a_cpu_rst, a_we, a_busy, a_done, a_err, a_ready});
    end
    tests++;
    if ({b_cpu_rst, b_we, b_busy, b_done, b_err, b_ready} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_b: got %b, expected 100000",
               {b_cpu_rst, b_we, b_busy, b_done, b_err, b_ready});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clear_load();
    push_clear_a();
    a_exp = 0;
    pulse_boot_a();
    tests++;
    if ({a_busy, a_ready, a_we} !== 3'b101) begin
      fails++;
      $display("FAIL clear_entry: busy,ready,we=%b, expected 101", {a_busy, a_ready, a_we});
    end
    send_a(32'hAAAA_0001, 1'b0);
    send_a(32'hBBBB_0002, 1'b0);
    send_a(32'hCCCC_0003, 1'b1);
    a_valid = 1'b0;
    a_last  = 1'b0;
    wait_release_a(8);
    check_drained("clear_load");
  endtask

  task automatic test_restart_from_run();
    push_clear_a();
    a_exp = 0;
    pulse_boot_a();
    tests++;
    if ({a_cpu_rst, a_done, a_busy, a_we} !== 4'b1011 || a_addr !== 4'd0) begin
      fails++;
      $display("FAIL restart_entry: cpu_reset,done,busy,we=%b addr=%0d, expected 1011 addr=0",
               {a_cpu_rst, a_done, a_busy, a_we}, a_addr);
    end
    for (int i = 0; i < 40; i++) begin
      if (a_ready) break;
      @(posedge clk); #1;
    end
    pulse_boot_a();
    tests++;
    if ({a_ready, a_busy, a_cpu_rst} !== 3'b111) begin
      fails++;
      $display("FAIL boot_in_load_ignored: ready,busy,cpu_reset=%b, expected 111",
               {a_ready, a_busy, a_cpu_rst});
    end
    for (int i = 0; i < 4; i++) send_a($urandom, (i == 3));
    a_valid = 1'b0;
    a_last  = 1'b0;
    wait_release_a(8);
    check_drained("restart");
  endtask

  task automatic test_reset_mid_load();
    logic bad;
    push_clear_a();
    a_exp = 0;
    pulse_boot_a();
    send_a(32'h1111_0000, 1'b0);
    send_a(32'h1111_0001, 1'b0);
    a_valid = 1'b0;
    @(posedge clk); #1;
    a_valid = 1'b1;
    a_data  = 32'h1111_0002;
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({a_cpu_rst, a_we, a_busy, a_done, a_err, a_ready} !== 6'b100000) begin
      fails++;
      $display("FAIL async_reset: got %b, expected 100000",
               {a_cpu_rst, a_we, a_busy, a_done, a_err, a_ready});
    end
    #2;
    reset_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if ({a_ready, a_we, a_busy, a_cpu_rst} !== 4'b0001) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL idle_after_reset: ready,we,busy,cpu_reset=%b, expected 0001",
               {a_ready, a_we, a_busy, a_cpu_rst});
    end
    a_valid = 1'b0;
    check_drained("reset_mid_load");
  endtask

  task automatic test_toggled_valid();
    int cyc;
    b_exp = 0;
    pulse_boot_b();
    for (int i = 0; i < 4; i++) begin
      send_b($urandom, (i == 3));
      b_valid = 1'b0;
      b_last  = 1'b0;
      @(posedge clk); #1;
    end
    cyc = 0;
    while (b_done !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if ({b_done, b_cpu_rst, b_err} !== 3'b100) begin
      fails++;
      $display("FAIL toggled_run: done,cpu_reset,error=%b, expected 100",
               {b_done, b_cpu_rst, b_err});
    end
    check_drained("toggled");
  endtask

  task automatic test_overflow();
    b_exp = 0;
    pulse_boot_b();
    for (int i = 0; i < 6; i++) begin
      send_b($urandom, (i == 5));
      if (i == 3) begin
        tests++;
        if (b_err !== 1'b0) begin
          fails++;
          $display("FAIL overflow_early: error=%b after word 4, expected 0", b_err);
        end
      end
      if (i == 4) begin
        tests++;
        if (b_err !== 1'b1) begin
          fails++;
          $display("FAIL overflow_flag: error=%b after word 5, expected 1", b_err);
        end
      end
    end
    b_valid = 1'b0;
    b_last  = 1'b0;
    tests++;
    if ({b_ready, b_busy, b_done, b_cpu_rst, b_err} !== 5'b00011) begin
      fails++;
      $display("FAIL overflow_idle: ready,busy,done,cpu_reset,error=%b, expected 00011",
               {b_ready, b_busy, b_done, b_cpu_rst, b_err});
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({b_done, b_cpu_rst, b_err} !== 3'b011) begin
      fails++;
      $display("FAIL overflow_stays: done,cpu_reset,error=%b, expected 011",
               {b_done, b_cpu_rst, b_err});
    end
    check_drained("overflow");
  endtask

  task automatic test_hold_zero();
    b_exp = 0;
    pulse_boot_b();
    tests++;
    if ({b_err, b_busy, b_ready} !== 3'b011) begin
      fails++;
      $display("FAIL boot_clears_error: error,busy,ready=%b, expected 011",
               {b_err, b_busy, b_ready});
    end
    send_b(32'hDEAD_BEEF, 1'b1);
    b_valid = 1'b0;
    b_last  = 1'b0;
    tests++;
    if ({b_we, b_cpu_rst} !== 2'b11) begin
      fails++;
      $display("FAIL final_write_cycle: we,cpu_reset=%b, expected 11", {b_we, b_cpu_rst});
    end
    @(posedge clk); #1;
    tests++;
    if ({b_we, b_cpu_rst, b_done} !== 3'b001) begin
      fails++;
      $display("FAIL hold_zero_release: we,cpu_reset,done=%b, expected 001",
               {b_we, b_cpu_rst, b_done});
    end
    check_drained("hold_zero");
  endtask

  initial begin
    test_reset();
    test_clear_load();
    test_restart_from_run();
    test_reset_mid_load();
    test_toggled_valid();
    test_overflow();
    test_hold_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
